// File: rtl/tthbif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tthbif_pkg
// Description : Shared types and constants for the tthbif RX tap trainer.
// Revision    : 1.0  initial release
// ============================================================================
package tthbif_pkg;

    // One tap select (4 flop taps x 4 comb taps)
    typedef logic [1:0] tap_sel_t;

    // Sweep sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        EVAL    = 3'd3,
        APPLY   = 3'd4
    } train_state_e;

    // PRBS7 (x^7 + x^6 + 1): history length and the two feedback positions
    localparam int c_PRBS7_W      = 7;
    localparam int c_PRBS7_TAP_HI = 6;
    localparam int c_PRBS7_TAP_LO = 5;

endpackage : tthbif_pkg
`default_nettype wire

// File: rtl/tthbif_tap_trainer_if.sv
`default_nettype none
// ============================================================================
// Module      : tthbif_tap_trainer_if
// Description : Control / status bundle between a sweep initiator and the
//               tap trainer. The master starts sweeps and supplies lane bits;
//               the slave (trainer) returns tap selects and results.
// Revision    : 1.0  initial release
// ============================================================================
interface tthbif_tap_trainer_if #(
    parameter int TAP_SEL_W = 2,
    parameter int ERR_W     = 9
);
    logic                 start_i;
    logic                 rx_i;
    logic [TAP_SEL_W-1:0] rx_flop_tap_sel_o;
    logic [TAP_SEL_W-1:0] rx_comb_tap_sel_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 lock_o;
    logic [ERR_W-1:0]     best_err_o;

    modport master (
        output start_i, rx_i,
        input  rx_flop_tap_sel_o, rx_comb_tap_sel_o, busy_o, done_o, lock_o, best_err_o
    );

    modport slave (
        input  start_i, rx_i,
        output rx_flop_tap_sel_o, rx_comb_tap_sel_o, busy_o, done_o, lock_o, best_err_o
    );
endinterface : tthbif_tap_trainer_if
`default_nettype wire

// File: rtl/tthbif_tap_trainer_prbs7_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs7_checker
// Description : Self-synchronising PRBS7 checker. The history register is
//               loaded with the received bits themselves, so after 7 clean
//               bits it is aligned with no seeding. A single flipped bit
//               produces three hits (as current bit, then at taps 5 and 6).
// Revision    : 1.0  initial release
// ============================================================================
module prbs7_checker
    import tthbif_pkg::*;
(
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic bit_i,
    output logic      err_o
);

    logic [c_PRBS7_W-1:0] r_hist;

    // History shifts every cycle regardless of what the trainer is doing
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hist <= '0;
        end else begin
            r_hist <= {r_hist[c_PRBS7_W-2:0], bit_i};
        end
    end

    assign err_o = bit_i ^ r_hist[c_PRBS7_TAP_HI] ^ r_hist[c_PRBS7_TAP_LO];

endmodule : prbs7_checker
`default_nettype wire

// File: rtl/tthbif_tap_trainer.sv
`default_nettype none
// ============================================================================
// Module      : tthbif_tap_trainer
// Description : Automatic RX tap-training controller for one tthbif lane.
//               Sweeps every {flop, comb} tap combination, scores each with
//               a PRBS7 checker and applies the one with the fewest errors.
// Revision    : 1.0  initial release
// ============================================================================
module tthbif_tap_trainer
    import tthbif_pkg::*;
#(
    parameter int TAP_SEL_W     = 2,
    parameter int SETTLE_CYCLES = 16,   // must be >= 8 to flush checker history
    parameter int WINDOW_CYCLES = 256,
    parameter int ERR_W         = 9     // $clog2(WINDOW_CYCLES+1)
)(
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    tthbif_tap_trainer_if.slave  bus
);

    localparam int c_IDX_W  = 2 * TAP_SEL_W;
    localparam int c_PH_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;

    localparam logic [c_PH_W-1:0]  c_SETTLE_LAST = c_PH_W'(SETTLE_CYCLES - 1);
    localparam logic [c_PH_W-1:0]  c_WINDOW_LAST = c_PH_W'(WINDOW_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST    = '1;
    localparam logic [ERR_W-1:0]   c_ERR_SAT     = '1;

    train_state_e         r_state;
    train_state_e         w_next;
    logic [c_PH_W-1:0]    r_phase;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   r_best_idx;
    logic [c_IDX_W-1:0]   r_applied;
    logic [ERR_W-1:0]     r_err_cnt;
    logic [ERR_W-1:0]     r_best_err;
    logic [ERR_W-1:0]     r_best_err_o;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_lock;
    logic                 w_chk_err;
    logic                 w_sweeping;

    prbs7_checker u_chk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bit_i (bus.rx_i),
        .err_o (w_chk_err)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: start is only honoured in IDLE, so APPLY always returns there
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_i)              w_next = SETTLE;
            SETTLE:  if (r_phase == c_SETTLE_LAST) w_next = MEASURE;
            MEASURE: if (r_phase == c_WINDOW_LAST) w_next = EVAL;
            EVAL:    w_next = (r_idx == c_IDX_LAST) ? APPLY : SETTLE;
            APPLY:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Shared SETTLE/MEASURE phase counter, restarts on every state change
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_phase <= '0;
        end else if ((r_state != w_next) || ((r_state != SETTLE) && (r_state != MEASURE))) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_PH_W'(1);
        end
    end

    // Sweep datapath: scoring, best-so-far tracking and result application
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_applied    <= '0;
            r_err_cnt    <= '0;
            r_best_err   <= '0;
            r_best_err_o <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_lock       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_idx      <= '0;
                        r_best_idx <= '0;
                        r_best_err <= c_ERR_SAT;
                        r_err_cnt  <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (w_chk_err && (r_err_cnt != c_ERR_SAT)) begin
                        r_err_cnt <= r_err_cnt + ERR_W'(1);
                    end
                end
                EVAL: begin
                    // Strict compare: on a tie the earlier (lower) index wins
                    if (r_err_cnt < r_best_err) begin
                        r_best_err <= r_err_cnt;
                        r_best_idx <= r_idx;
                    end
                    r_err_cnt <= '0;
                    if (r_idx != c_IDX_LAST) begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                APPLY: begin
                    r_applied    <= r_best_idx;
                    r_best_err_o <= r_best_err;
                    r_lock       <= (r_best_err == '0);
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Taps follow the index under test while sweeping, else the applied result
    assign w_sweeping = (r_state == SETTLE) || (r_state == MEASURE) || (r_state == EVAL);

    assign bus.rx_flop_tap_sel_o = w_sweeping ? r_idx[c_IDX_W-1:TAP_SEL_W]
                                              : r_applied[c_IDX_W-1:TAP_SEL_W];
    assign bus.rx_comb_tap_sel_o = w_sweeping ? r_idx[TAP_SEL_W-1:0]
                                              : r_applied[TAP_SEL_W-1:0];
    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.lock_o     = r_lock;
    assign bus.best_err_o = r_best_err_o;

endmodule : tthbif_tap_trainer
`default_nettype wire

// File: tb/tb_tthbif_tap_trainer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tthbif_tap_trainer
// Description : Directed self-checking bench for tthbif_tap_trainer. The
//               lane stimulus is generated from the bench's own cycle count,
//               so the index under test is known without reading the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tthbif_tap_trainer;

    localparam int SETTLE = 16;
    localparam int WINDOW = 256;
    localparam int SEG    = SETTLE + WINDOW + 1;       // cycles per index
    localparam int LAT    = 1 + 16 * SEG + 1;          // start cycle -> done cycle

    localparam int M_GOOD  = 0;   // clean PRBS at one index, random elsewhere
    localparam int M_ONES  = 1;   // lane stuck at 1
    localparam int M_ZEROS = 2;   // lane stuck at 0
    localparam int M_INJ   = 3;   // PRBS at idx 4 and 5 with 3 flipped bits each

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [6:0] prbs_s;
    int   lat;
    int   ndone;

    tthbif_tap_trainer_if #(.TAP_SEL_W(2), .ERR_W(9)) bus ();

    tthbif_tap_trainer #(
        .TAP_SEL_W     (2),
        .SETTLE_CYCLES (SETTLE),
        .WINDOW_CYCLES (WINDOW),
        .ERR_W         (9)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference PRBS7 generator, b[n] = b[n-7] ^ b[n-6]
    function automatic logic prbs_step();
        logic b;
        b      = prbs_s[6] ^ prbs_s[5];
        prbs_s = {prbs_s[5:0], b};
        return b;
    endfunction

    // Lane bit for bench cycle j (cycle 1 is the first SETTLE cycle of idx 0)
    function automatic logic rx_for(input int mode, input int good, input int j);
        int   p;
        int   k;
        int   o;
        logic pb;
        logic rb;
        pb = prbs_step();
        rb = 1'($urandom_range(1, 0));
        if (mode == M_ONES)  return 1'b1;
        if (mode == M_ZEROS) return 1'b0;
        if (j < 1) return rb;
        p = j - 1;
        k = p / SEG;
        o = p % SEG;
        if (k > 15) return rb;
        if (mode == M_GOOD) return (k == good) ? pb : rb;
        if (k == 4 || k == 5) begin
            if (o == SETTLE + 20 || o == SETTLE + 100 || o == SETTLE + 200) return ~pb;
            return pb;
        end
        return rb;
    endfunction

    // One sweep: pulse start, drive the lane, optionally re-pulse start or reset
    task automatic sweep(input int mode, input int good, input int restart_at,
                         input int extra_at, input int rst_at,
                         input logic hold_lock, input int hold_err,
                         output int o_lat, output int o_ndone);
        int k;
        o_lat   = 0;
        o_ndone = 0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.rx_i    = rx_for(mode, good, 0);
        for (int j = 1; j <= LAT + 5; j++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                o_ndone++;
                if (o_lat == 0) o_lat = j;
            end
            if (j == 1) check("busy_rise", 32'(bus.busy_o), 32'd1);
            if (j == 2) begin
                check("lock_held", 32'(bus.lock_o), 32'(hold_lock));
                check("best_err_held", 32'(bus.best_err_o), 32'(hold_err));
            end
            if (mode == M_GOOD && (j == 51 || j == 6 * SEG + 51 || j == 15 * SEG + 51)) begin
                k = (j - 1) / SEG;
                check("sweep_flop_sel", 32'(bus.rx_flop_tap_sel_o), 32'(k / 4));
                check("sweep_comb_sel", 32'(bus.rx_comb_tap_sel_o), 32'(k % 4));
            end
            if (extra_at > 0 && (j == extra_at + 1 || j == extra_at + 2))
                check("apply_start_ignored", 32'(bus.busy_o), 32'd0);
            if (j == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_flop_sel", 32'(bus.rx_flop_tap_sel_o), 32'd0);
                check("rst_comb_sel", 32'(bus.rx_comb_tap_sel_o), 32'd0);
                check("rst_busy", 32'(bus.busy_o), 32'd0);
                check("rst_done", 32'(bus.done_o), 32'd0);
                check("rst_lock", 32'(bus.lock_o), 32'd0);
                check("rst_best_err", 32'(bus.best_err_o), 32'd0);
                bus.start_i = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            bus.start_i = (j == restart_at) || (j == extra_at);
            bus.rx_i    = rx_for(mode, good, j);
        end
        bus.start_i = 1'b0;
    endtask

    task automatic check_result(input string tag, input int exp_flop, input int exp_comb,
                                input logic exp_lock, input int exp_err);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check({tag, "_flop_sel"}, 32'(bus.rx_flop_tap_sel_o), 32'(exp_flop));
        check({tag, "_comb_sel"}, 32'(bus.rx_comb_tap_sel_o), 32'(exp_comb));
        check({tag, "_lock"}, 32'(bus.lock_o), 32'(exp_lock));
        check({tag, "_best_err"}, 32'(bus.best_err_o), 32'(exp_err));
        check({tag, "_busy_end"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        prbs_s      = 7'h01;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.rx_i    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flop_sel", 32'(bus.rx_flop_tap_sel_o), 32'd0);
        check("reset_comb_sel", 32'(bus.rx_comb_tap_sel_o), 32'd0);
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        check("reset_done", 32'(bus.done_o), 32'd0);
        check("reset_lock", 32'(bus.lock_o), 32'd0);
        check("reset_best_err", 32'(bus.best_err_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean PRBS only at idx 9 -> flop 2, comb 1, locked
        sweep(M_GOOD, 9, 0, 0, 0, 1'b0, 0, lat, ndone);
        check_result("good9", 2, 1, 1'b1, 0);

        // Stuck-at-0 lane scores zero everywhere -> idx 0; extra starts ignored
        sweep(M_ZEROS, 0, 100, LAT - 1, 0, 1'b1, 0, lat, ndone);
        check_result("zeros_restart", 0, 0, 1'b1, 0);

        // Three flipped bits at idx 4 and 5 (9 hits each); tie keeps idx 4
        sweep(M_INJ, 0, 0, 0, 0, 1'b1, 0, lat, ndone);
        check_result("inject", 1, 0, 1'b0, 9);

        // Lane stuck at 1: every bit mismatches, window-limited to 256
        sweep(M_ONES, 0, 0, 0, 0, 1'b0, 9, lat, ndone);
        check_result("ones", 0, 0, 1'b0, 256);

        // Reset in MEASURE at idx 7, then a complete fresh sweep
        sweep(M_GOOD, 9, 0, 0, 7 * SEG + SETTLE + 101, 1'b0, 256, lat, ndone);
        check("abort_no_done", 32'(ndone), 32'd0);
        repeat (2) @(negedge clk);
        sweep(M_GOOD, 6, 0, 0, 0, 1'b0, 0, lat, ndone);
        check_result("after_reset", 1, 2, 1'b1, 0);

        // Back-to-back sweeps: idx 3 then idx 12
        sweep(M_GOOD, 3, 0, 0, 0, 1'b1, 0, lat, ndone);
        check_result("b2b_first", 0, 3, 1'b1, 0);
        repeat (5) @(negedge clk);
        check("idle_hold_flop", 32'(bus.rx_flop_tap_sel_o), 32'd0);
        check("idle_hold_comb", 32'(bus.rx_comb_tap_sel_o), 32'd3);
        sweep(M_GOOD, 12, 0, 0, 0, 1'b1, 0, lat, ndone);
        check_result("b2b_second", 3, 0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tthbif_tap_trainer
`default_nettype wire
